// File: rtl/cursor_pos_sched_if.sv
// Request/grant and position bus between the two cursor sources and the position scheduler.
// The scheduler takes the slave side; the source logic (or a bench) takes the master side.
interface cursor_pos_sched_if;
  logic        req_a;
  logic [11:0] xpos_a;
  logic [11:0] ypos_a;
  logic        req_b;
  logic [11:0] xpos_b;
  logic [11:0] ypos_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [11:0] xpos_out;
  logic [11:0] ypos_out;
  logic        upd;
  logic        src;
  logic        busy;

  modport master (
    output req_a, xpos_a, ypos_a, req_b, xpos_b, ypos_b,
    input  gnt_a, gnt_b, xpos_out, ypos_out, upd, src, busy
  );

  modport slave (
    input  req_a, xpos_a, ypos_a, req_b, xpos_b, ypos_b,
    output gnt_a, gnt_b, xpos_out, ypos_out, upd, src, busy
  );
endinterface

// File: rtl/cursor_pos_sched.sv
// Round-robin scheduler publishing mouse (A) / keyboard (B) cursor positions, each held HOLD_CYCLES.
// Optional CURSOR_CLAMP_EN clamps latched coordinates to XMAX/YMAX.
module cursor_pos_sched #(
  parameter int HOLD_CYCLES = 8,
  parameter int XMAX        = 1023,
  parameter int YMAX        = 767
) (
  input  logic               clk100MHz,
  input  logic               rst,
  cursor_pos_sched_if.slave  bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        upd_q, upd_d;
  logic        src_q, src_d;
  logic        busy_q, busy_d;

  logic        pick_b;
  logic [11:0] sel_x;
  logic [11:0] sel_y;

`ifdef CURSOR_CLAMP_EN
  function automatic logic [11:0] clamp_to(input logic [11:0] v, input int lim);
    return ({20'd0, v} > 32'(lim)) ? 12'(lim) : v;
  endfunction
`else
  localparam int unused_clamp_limits = XMAX + YMAX;
`endif

  // On a tie, the source that did not win last time gets the grant.
  assign pick_b = bus.req_b && (!bus.req_a || !src_q);

  always_comb begin
`ifdef CURSOR_CLAMP_EN
    sel_x = clamp_to(pick_b ? bus.xpos_b : bus.xpos_a, XMAX);
    sel_y = clamp_to(pick_b ? bus.ypos_b : bus.ypos_a, YMAX);
`else
    sel_x = pick_b ? bus.xpos_b : bus.xpos_a;
    sel_y = pick_b ? bus.ypos_b : bus.ypos_a;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    src_d   = src_q;
    busy_d  = busy_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          xpos_d  = sel_x;
          ypos_d  = sel_y;
          gnt_a_d = !pick_b;
          gnt_b_d = pick_b;
          upd_d   = 1'b1;
          src_d   = pick_b;
          busy_d  = 1'b1;
        end
      end
      HOLD: begin
        // Requests are deliberately ignored here; they are level and stay up until granted.
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      xpos_q  <= 12'd0;
      ypos_q  <= 12'd0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      upd_q   <= 1'b0;
      src_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      upd_q   <= upd_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.xpos_out = xpos_q;
  assign bus.ypos_out = ypos_q;
  assign bus.upd      = upd_q;
  assign bus.src      = src_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cursor_pos_sched.sv
// Directed bench for cursor_pos_sched: reset, single grant, hold, contention, clamp, reset mid-hold.
// Expected clamp values follow CURSOR_CLAMP_EN.
module tb_cursor_pos_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cursor_pos_sched_if bus ();

  cursor_pos_sched #(.HOLD_CYCLES(8), .XMAX(1023), .YMAX(767)) dut (
    .clk100MHz (clk),
    .rst       (rst),
    .bus       (bus)
  );

`ifdef CURSOR_CLAMP_EN
  localparam int EXP_CLAMP_X = 1023;
  localparam int EXP_CLAMP_Y = 767;
`else
  localparam int EXP_CLAMP_X = 1500;
  localparam int EXP_CLAMP_Y = 900;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.busy !== 1'b0; i++) @(negedge clk);
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt_a"}, {31'd0, bus.gnt_a}, 32'd0);
    check({tag, "_gnt_b"}, {31'd0, bus.gnt_b}, 32'd0);
    check({tag, "_upd"},   {31'd0, bus.upd},   32'd0);
    check({tag, "_x"},     {20'd0, bus.xpos_out}, 32'd0);
    check({tag, "_y"},     {20'd0, bus.ypos_out}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy},  32'd0);
    check({tag, "_src"},   {31'd0, bus.src},   32'd1);
  endtask

  initial begin
    int nb;
    int stray;
    int d;
    int got;
    int ng;
    int both;
    int gcyc[4];
    logic gsrc[4];

    bus.req_a = 1'b0; bus.xpos_a = '0; bus.ypos_a = '0;
    bus.req_b = 1'b0; bus.xpos_b = '0; bus.ypos_b = '0;
    foreach (gcyc[i]) begin gcyc[i] = 0; gsrc[i] = 1'b0; end

    // Asynchronous reset asserted between clock edges.
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("step reset: checks=%0d failures=%0d", checks, failures);

    // Single request from A.
    bus.req_a = 1'b1; bus.xpos_a = 12'd100; bus.ypos_a = 12'd200;
    @(negedge clk);
    check("single_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
    check("single_gnt_b", {31'd0, bus.gnt_b}, 32'd0);
    check("single_upd",   {31'd0, bus.upd},   32'd1);
    check("single_x",     {20'd0, bus.xpos_out}, 32'd100);
    check("single_y",     {20'd0, bus.ypos_out}, 32'd200);
    check("single_src",   {31'd0, bus.src},   32'd0);
    bus.req_a = 1'b0;
    nb = 0; stray = 0;
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
      nb++;
      if (i > 0 && (bus.upd || bus.gnt_a || bus.gnt_b)) stray++;
      @(negedge clk);
    end
    check("single_busy_cycles", nb, 8);
    check("single_stray_pulses", stray, 0);
    check("single_x_held", {20'd0, bus.xpos_out}, 32'd100);
    $display("step single: busy_cycles=%0d checks=%0d failures=%0d", nb, checks, failures);

    // Request from B raised while A's position is held.
    bus.req_a = 1'b1; bus.xpos_a = 12'd10; bus.ypos_a = 12'd20;
    @(negedge clk);
    check("hold_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
    bus.req_a = 1'b0;
    d = 0; got = 0;
    for (int i = 0; i < 30 && got == 0; i++) begin
      @(negedge clk);
      d++;
      if (d == 2) begin
        bus.req_b = 1'b1; bus.xpos_b = 12'd30; bus.ypos_b = 12'd40;
      end
      if (bus.gnt_b === 1'b1) got = 1;
    end
    check("hold_gnt_b_seen", got, 1);
    check("hold_gnt_b_delay", d, 9);
    check("hold_b_x", {20'd0, bus.xpos_out}, 32'd30);
    check("hold_b_y", {20'd0, bus.ypos_out}, 32'd40);
    check("hold_b_src", {31'd0, bus.src}, 32'd1);
    bus.req_b = 1'b0;
    $display("step hold: gnt_b_delay=%0d checks=%0d failures=%0d", d, checks, failures);

    // Contention right after reset: A first, then alternating.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("cont_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_a = 1'b1; bus.xpos_a = 12'd1; bus.ypos_a = 12'd2;
    bus.req_b = 1'b1; bus.xpos_b = 12'd3; bus.ypos_b = 12'd4;
    ng = 0; both = 0;
    for (int c = 1; c <= 60 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.gnt_a && bus.gnt_b) both++;
      if (bus.gnt_a || bus.gnt_b) begin
        gcyc[ng] = c;
        gsrc[ng] = bus.gnt_b;
        check("cont_x", {20'd0, bus.xpos_out}, bus.gnt_b ? 32'd3 : 32'd1);
        ng++;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    check("cont_grant_count", ng, 4);
    check("cont_simultaneous", both, 0);
    check("cont_src0", {31'd0, gsrc[0]}, 32'd0);
    check("cont_src1", {31'd0, gsrc[1]}, 32'd1);
    check("cont_src2", {31'd0, gsrc[2]}, 32'd0);
    check("cont_src3", {31'd0, gsrc[3]}, 32'd1);
    check("cont_first_cycle", gcyc[0], 1);
    for (int k = 1; k < 4; k++) check("cont_spacing", gcyc[k] - gcyc[k-1], 9);
    $display("step contention: grants=%0d checks=%0d failures=%0d", ng, checks, failures);

    // Out-of-range coordinates.
    wait_idle("clamp_idle");
    bus.req_a = 1'b1; bus.xpos_a = 12'd1500; bus.ypos_a = 12'd900;
    @(negedge clk);
    bus.req_a = 1'b0;
    check("clamp_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
    check("clamp_x", {20'd0, bus.xpos_out}, EXP_CLAMP_X);
    check("clamp_y", {20'd0, bus.ypos_out}, EXP_CLAMP_Y);
    $display("step clamp: x=%0d y=%0d checks=%0d failures=%0d", bus.xpos_out, bus.ypos_out, checks, failures);

    // Reset three cycles into B's hold, then a tie must go to A.
    wait_idle("midrst_idle");
    bus.req_b = 1'b1; bus.xpos_b = 12'd55; bus.ypos_b = 12'd66;
    @(negedge clk);
    bus.req_b = 1'b0;
    check("midrst_gnt_b", {31'd0, bus.gnt_b}, 32'd1);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.req_a = 1'b1; bus.xpos_a = 12'd7;  bus.ypos_a = 12'd8;
    bus.req_b = 1'b1; bus.xpos_b = 12'd9;  bus.ypos_b = 12'd11;
    @(negedge clk);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    check("midrst_tie_gnt_a", {31'd0, bus.gnt_a}, 32'd1);
    check("midrst_tie_gnt_b", {31'd0, bus.gnt_b}, 32'd0);
    check("midrst_tie_upd",   {31'd0, bus.upd},   32'd1);
    check("midrst_tie_x",     {20'd0, bus.xpos_out}, 32'd7);
    $display("step midrst: checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
